block_slot_scheduler: RTL
=========================

BLOCK_SLOT_SCHEDULER -- requirements
Module: block_slot_scheduler

Interface
REQ-001 Parameter SPAWN_H, default 120: height loaded into a slot on allocation.
REQ-002 Parameter FLOOR_H, default 720: height at which a falling block leaves the screen.
REQ-003 Parameter HIT_MIN, default 600: minimum height at which a hit is accepted.
REQ-004 Port clk, input, 1: single clock; all state SHALL update on its rising edge only.
REQ-005 Port rst, input, 1: reset, synchronous, active-high.
REQ-006 Port restart, input, 1: synchronous game restart, same effect as rst.
REQ-007 Port stop_or_endgame, input, 1: freezes all slot heights and allocation while high.
REQ-008 Port beat_cnt, input, 7: current beat index, non-decreasing except on restart.
REQ-009 Port spawn_req, input, 4: per-lane spawn request, sampled only on a beat-advance cycle.
REQ-010 Port hit_lane, input, 4: per-lane single-cycle player hit pulse.
REQ-011 Port slot_valid, output, 4: slot i holds a falling block.
REQ-012 Port slot_lane, output, 8: lane of slot i in bits [2i+1:2i].
REQ-013 Port slot_h, output, 40: height of slot i in bits [10i+9:10i].
REQ-014 Port hit_ok, output, 1: single-cycle pulse when a hit retires a slot.
REQ-015 Port miss, output, 1: single-cycle pulse when a slot reaches FLOOR_H.
REQ-016 Port drop, output, 1: single-cycle pulse when a pending request is discarded.

Function
REQ-017 Beat advance SHALL be detected as beat_cnt greater than its value registered on the previous cycle.
REQ-018 States SHALL be IDLE, RUN, HOLD; IDLE->RUN on the first beat advance; RUN->HOLD when stop_or_endgame=1; HOLD->RUN when stop_or_endgame=0.
REQ-019 In RUN, on a beat advance, spawn_req SHALL be loaded into a 4-bit pending mask.
REQ-020 If any pending bit is still set at a beat advance, those lanes are discarded, drop pulses for one cycle, and the mask takes the new spawn_req.
REQ-021 In RUN, each cycle, the lowest-index pending lane SHALL be allocated to the lowest-index free slot: valid=1, lane set, height=SPAWN_H, pending bit cleared. At most one allocation SHALL occur per cycle.
REQ-022 If no slot is free, the pending lane SHALL wait and remain set.
REQ-023 A slot freed in cycle N SHALL NOT be allocatable before cycle N+1.
REQ-024 In RUN, each valid slot not allocated or freed this cycle SHALL increment its height by 1 per cycle, saturating at FLOOR_H.
REQ-025 A valid slot whose height equals FLOOR_H SHALL be freed the next cycle with miss=1.
REQ-026 If several slots miss in the same cycle, all SHALL be freed and miss SHALL pulse once.
REQ-027 On hit_lane[l] in RUN, the valid slot of lane l with the greatest height SHALL be freed and hit_ok=1, but only if that height is at least HIT_MIN. Ties SHALL go to the lowest slot index.
REQ-028 A hit on a lane with no qualifying slot SHALL be ignored, with no pulse.
REQ-029 A hit on a slot at FLOOR_H in the same cycle SHALL count as a hit: hit_ok=1 and miss=0 for that slot.
REQ-030 Hits on several lanes in the same cycle SHALL each be processed, with a single hit_ok pulse.
REQ-031 In HOLD and IDLE, heights, the pending mask, allocation and hits SHALL be frozen or ignored, and all pulses SHALL be 0.
REQ-032 Heights SHALL be 10-bit unsigned, and no value above FLOOR_H SHALL ever be output.

Reset
REQ-033 On rst or restart, state=IDLE, slot_valid=0, slot_lane=0, slot_h=FLOOR_H in every field, pending=0, registered beat=0, and all pulses=0, on the following clock edge.
REQ-034 rst or restart asserted mid-operation SHALL override every other event in that cycle.

Verification
REQ-035 Reset, then beat_cnt 0->2 with spawn_req=0101 -> slot0 gets lane0 (h=120) and slot1 gets lane2 (h=120) on consecutive cycles.
REQ-036 A single block runs 600 cycles in RUN -> h=720, then slot frees with miss=1 for one cycle.
REQ-037 Four slots valid, beat with spawn_req=0001, second beat before any slot frees -> drop=1, and the mask takes the new request.
REQ-038 Lane1 slot at h=600 with hit_lane=0010 -> slot freed, hit_ok=1. Same at h=599 -> no effect.
REQ-039 stop_or_endgame=1 for 50 cycles mid-fall -> heights unchanged. On release, incrementing resumes at the next cycle.
REQ-040 restart asserted in the same cycle as a hit and a miss -> all outputs at reset values, with no pulses.

Source files
------------

// File: rtl/block_slot_scheduler.sv
// Four-slot falling-block scheduler: queues per-lane spawn requests on beat
// advances, drops blocks toward the floor and retires them on hit or miss.
module block_slot_scheduler #(
  parameter int SPAWN_H = 120,
  parameter int FLOOR_H = 720,
  parameter int HIT_MIN = 600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  input  logic        stop_or_endgame,
  input  logic [6:0]  beat_cnt,
  input  logic [3:0]  spawn_req,
  input  logic [3:0]  hit_lane,
  output logic [3:0]  slot_valid,
  output logic [7:0]  slot_lane,
  output logic [39:0] slot_h,
  output logic        hit_ok,
  output logic        miss,
  output logic        drop
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  localparam logic [9:0] SPAWN_V = 10'(SPAWN_H);
  localparam logic [9:0] FLOOR_V = 10'(FLOOR_H);
  localparam logic [9:0] HIT_V   = 10'(HIT_MIN);

  state_t      state_q, state_n;
  logic [6:0]  beat_q;
  logic [3:0]  pending_q, pending_n;
  logic [3:0]  valid_q, valid_n;
  logic [1:0]  lane_q [4];
  logic [1:0]  lane_n [4];
  logic [9:0]  h_q [4];
  logic [9:0]  h_n [4];
  logic        hit_ok_n, miss_n, drop_n;

  logic        beat_adv;
  logic        active;
  logic        load_req;
  logic [3:0]  miss_mask;
  logic [3:0]  hit_mask;
  logic [3:0]  free_mask;

  logic        best_found;
  logic [1:0]  best_idx;
  logic [9:0]  best_h;

  logic        alloc_en;
  logic        lane_found;
  logic        slot_found;
  logic [1:0]  alloc_lane;
  logic [1:0]  alloc_slot;

  assign beat_adv = beat_cnt > beat_q;
  assign active   = (state_q == RUN) && !stop_or_endgame;
  // The beat that wakes the scheduler from IDLE also captures its spawn request.
  assign load_req = beat_adv && (active || (state_q == IDLE));

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE:    if (beat_adv) state_n = RUN;
      RUN:     if (stop_or_endgame) state_n = HOLD;
      HOLD:    if (!stop_or_endgame) state_n = RUN;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    miss_mask = '0;
    for (int unsigned s = 0; s < 4; s++) begin
      miss_mask[s] = valid_q[s] && (h_q[s] == FLOOR_V);
    end
  end

  // Per lane, pick the lowest valid slot holding the greatest height.
  always_comb begin
    hit_mask   = '0;
    best_found = 1'b0;
    best_idx   = '0;
    best_h     = '0;
    for (int unsigned l = 0; l < 4; l++) begin
      best_found = 1'b0;
      best_idx   = '0;
      best_h     = '0;
      for (int unsigned s = 0; s < 4; s++) begin
        if (valid_q[s] && (lane_q[s] == 2'(l)) && (!best_found || (h_q[s] > best_h))) begin
          best_found = 1'b1;
          best_idx   = 2'(s);
          best_h     = h_q[s];
        end
      end
      if (hit_lane[l] && best_found && (best_h >= HIT_V)) begin
        hit_mask[best_idx] = 1'b1;
      end
    end
  end

  assign free_mask = hit_mask | miss_mask;

  // Only slots already empty at the start of the cycle are candidates.
  always_comb begin
    lane_found = 1'b0;
    slot_found = 1'b0;
    alloc_lane = '0;
    alloc_slot = '0;
    for (int unsigned l = 0; l < 4; l++) begin
      if (!lane_found && pending_q[l]) begin
        lane_found = 1'b1;
        alloc_lane = 2'(l);
      end
    end
    for (int unsigned s = 0; s < 4; s++) begin
      if (!slot_found && !valid_q[s]) begin
        slot_found = 1'b1;
        alloc_slot = 2'(s);
      end
    end
    alloc_en = active && !beat_adv && lane_found && slot_found;
  end

  always_comb begin
    valid_n   = valid_q;
    lane_n    = lane_q;
    h_n       = h_q;
    pending_n = pending_q;
    hit_ok_n  = 1'b0;
    miss_n    = 1'b0;
    drop_n    = 1'b0;
    if (active) begin
      for (int unsigned s = 0; s < 4; s++) begin
        if (free_mask[s]) begin
          valid_n[s] = 1'b0;
          lane_n[s]  = '0;
          h_n[s]     = FLOOR_V;
        end else if (valid_q[s] && (h_q[s] < FLOOR_V)) begin
          h_n[s] = h_q[s] + 10'd1;
        end
      end
      if (alloc_en) begin
        valid_n[alloc_slot]   = 1'b1;
        lane_n[alloc_slot]    = alloc_lane;
        h_n[alloc_slot]       = SPAWN_V;
        pending_n[alloc_lane] = 1'b0;
      end
      hit_ok_n = |hit_mask;
      miss_n   = |(miss_mask & ~hit_mask);
      drop_n   = beat_adv && (|pending_q);
    end
    if (load_req) begin
      pending_n = spawn_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      pending_q <= '0;
      valid_q   <= '0;
      hit_ok    <= 1'b0;
      miss      <= 1'b0;
      drop      <= 1'b0;
      for (int unsigned s = 0; s < 4; s++) begin
        lane_q[s] <= '0;
        h_q[s]    <= FLOOR_V;
      end
    end else begin
      state_q   <= state_n;
      beat_q    <= beat_cnt;
      pending_q <= pending_n;
      valid_q   <= valid_n;
      hit_ok    <= hit_ok_n;
      miss      <= miss_n;
      drop      <= drop_n;
      for (int unsigned s = 0; s < 4; s++) begin
        lane_q[s] <= lane_n[s];
        h_q[s]    <= h_n[s];
      end
    end
  end

  always_comb begin
    slot_valid = valid_q;
    slot_lane  = '0;
    slot_h     = '0;
    for (int unsigned s = 0; s < 4; s++) begin
      slot_lane[2*s +: 2] = lane_q[s];
      slot_h[10*s +: 10]  = h_q[s];
    end
  end

endmodule
